// File: rtl/theta_pkg.sv
// Shared types and widths for the thetaCos sweep sequencer.
package theta_pkg;

    localparam int ITER_W = 12;
    localparam int RES_W  = 34;
    localparam int COL_W  = 9;
    localparam int FRM_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        REQ  = 2'd2,
        OUT  = 2'd3
    } theta_state_e;

    function automatic logic rise_edge(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/theta_scan_cnt.sv
// Column/frame/index counter for the sweep; the index wraps together with the frame on the last point.
module theta_scan_cnt
    import theta_pkg::*;
#(
    parameter int FRAME_COLUMNS_P = 360,
    parameter int FRAME_NUMBER_P  = 5
) (
    input  logic              clk_i,
    input  logic              nrst_i,
    input  logic              clr_i,
    input  logic              adv_i,
    output logic [ITER_W-1:0] index_o,
    output logic [COL_W-1:0]  column_o,
    output logic [FRM_W-1:0]  frame_o,
    output logic              last_o
);

    localparam int TOTAL_POINTS_P = FRAME_COLUMNS_P * FRAME_NUMBER_P;
    localparam logic [ITER_W-1:0] LAST_IDX = ITER_W'(TOTAL_POINTS_P - 1);
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(FRAME_COLUMNS_P - 1);

    logic [ITER_W-1:0] r_index;
    logic [COL_W-1:0]  r_column;
    logic [FRM_W-1:0]  r_frame;
    logic              w_col_wrap;
    logic              w_last;

    assign w_col_wrap = (r_column == LAST_COL);
    assign w_last     = (r_index == LAST_IDX);

    // Point counters: clear wins over advance
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_index  <= '0;
            r_column <= '0;
            r_frame  <= '0;
        end else if (clr_i) begin
            r_index  <= '0;
            r_column <= '0;
            r_frame  <= '0;
        end else if (adv_i) begin
            if (w_last) begin
                r_index  <= '0;
                r_column <= '0;
                r_frame  <= '0;
            end else begin
                r_index <= r_index + ITER_W'(1);
                if (w_col_wrap) begin
                    r_column <= '0;
                    r_frame  <= r_frame + FRM_W'(1);
                end else begin
                    r_column <= r_column + COL_W'(1);
                end
            end
        end else begin
            r_index  <= r_index;
            r_column <= r_column;
            r_frame  <= r_frame;
        end
    end

    assign index_o  = r_index;
    assign column_o = r_column;
    assign frame_o  = r_frame;
    assign last_o   = w_last;

endmodule

// File: rtl/theta_sweep_seq.sv
// Sweep sequencer for the thetaCos datapath: one request in flight, tagged results out over valid/ready.
// Optional request timeout is compiled in with THETA_SWEEP_TIMEOUT_EN.
module theta_sweep_seq
    import theta_pkg::*;
#(
    parameter int FRAME_COLUMNS_P = 360,
    parameter int FRAME_NUMBER_P  = 5,
    parameter int GAP_CYCLES_P    = 2,
    parameter int TIMEOUT_P       = 4096
) (
    input  logic              clk_i,
    input  logic              nrst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              continuous_i,
    output logic              theta_iteration_valid_o,
    output logic [ITER_W-1:0] theta_iteration_o,
    input  logic              thetaCos_valid_i,
    input  logic [RES_W-1:0]  thetaCos_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [RES_W-1:0]  res_data_o,
    output logic [COL_W-1:0]  res_column_o,
    output logic [FRM_W-1:0]  res_frame_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              timeout_o
);

    localparam int GAP_W = (GAP_CYCLES_P > 1) ? $clog2(GAP_CYCLES_P) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES_P - 1);

    theta_state_e      r_state;
    theta_state_e      w_next_state;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic              r_valid_q;
    logic              r_req_valid;
    logic              r_res_valid;
    logic [RES_W-1:0]  r_res_data;
    logic [COL_W-1:0]  r_res_col;
    logic [FRM_W-1:0]  r_res_frm;
    logic              r_busy;
    logic              r_done;
    logic              w_edge;
    logic              w_handshake;
    logic              w_start_ok;
    logic              w_timeout_exp;
    logic              w_capture;
    logic              w_cnt_clr;
    logic              w_cnt_adv;
    logic              w_done;
    logic [ITER_W-1:0] w_index;
    logic [COL_W-1:0]  w_column;
    logic [FRM_W-1:0]  w_frame;
    logic              w_last;

    theta_scan_cnt #(
        .FRAME_COLUMNS_P (FRAME_COLUMNS_P),
        .FRAME_NUMBER_P  (FRAME_NUMBER_P)
    ) u_scan_cnt (
        .clk_i    (clk_i),
        .nrst_i   (nrst_i),
        .clr_i    (w_cnt_clr),
        .adv_i    (w_cnt_adv),
        .index_o  (w_index),
        .column_o (w_column),
        .frame_o  (w_frame),
        .last_o   (w_last)
    );

    // A level that is already high when REQ is entered must not count as a result
    assign w_edge      = rise_edge(thetaCos_valid_i, r_valid_q);
    assign w_handshake = r_res_valid & res_ready_i;
    assign w_start_ok  = (r_state == IDLE) & start_i & ~abort_i;

    // Next-state and per-cycle control decode; abort overrides everything
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_adv    = 1'b0;
        w_done       = 1'b0;
        if (abort_i) begin
            w_next_state = IDLE;
            w_cnt_clr    = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        w_next_state = GAP;
                        w_cnt_clr    = 1'b1;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
                GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        w_next_state = REQ;
                    end else begin
                        w_next_state = GAP;
                    end
                end
                REQ: begin
                    if (w_edge) begin
                        w_next_state = OUT;
                        w_capture    = 1'b1;
                    end else if (w_timeout_exp) begin
                        w_next_state = IDLE;
                    end else begin
                        w_next_state = REQ;
                    end
                end
                OUT: begin
                    if (w_handshake) begin
                        w_cnt_adv = 1'b1;
                        w_done    = w_last;
                        if (w_last && !continuous_i) begin
                            w_next_state = IDLE;
                        end else begin
                            w_next_state = GAP;
                        end
                    end else begin
                        w_next_state = OUT;
                    end
                end
                default: begin
                    w_next_state = IDLE;
                end
            endcase
        end
    end

    // State, gap timer and registered control outputs
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_state     <= IDLE;
            r_gap_cnt   <= '0;
            r_valid_q   <= 1'b0;
            r_req_valid <= 1'b0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_gap_cnt   <= (r_state == GAP) ? r_gap_cnt + GAP_W'(1) : '0;
            r_valid_q   <= thetaCos_valid_i;
            r_req_valid <= (w_next_state == REQ);
            r_res_valid <= (w_next_state == OUT);
            r_busy      <= (w_next_state != IDLE);
            r_done      <= w_done;
        end
    end

    // Result register: loaded on capture, held through backpressure, wiped by abort
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_res_data <= '0;
            r_res_col  <= '0;
            r_res_frm  <= '0;
        end else if (abort_i) begin
            r_res_data <= '0;
            r_res_col  <= '0;
            r_res_frm  <= '0;
        end else if (w_capture) begin
            r_res_data <= thetaCos_i;
            r_res_col  <= w_column;
            r_res_frm  <= w_frame;
        end else begin
            r_res_data <= r_res_data;
            r_res_col  <= r_res_col;
            r_res_frm  <= r_res_frm;
        end
    end

`ifdef THETA_SWEEP_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_P > 1) ? $clog2(TIMEOUT_P) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_P - 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout;
    logic            w_timeout_hit;

    assign w_timeout_exp = (r_to_cnt == TO_LAST);
    assign w_timeout_hit = (r_state == REQ) & ~abort_i & ~w_edge & w_timeout_exp;

    // Cycles spent waiting in REQ, restarted on every entry
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_to_cnt <= '0;
        end else if (r_state == REQ) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end else begin
            r_to_cnt <= '0;
        end
    end

    // Sticky timeout flag, cleared only by an accepted start
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_timeout <= 1'b0;
        end else if (w_timeout_hit) begin
            r_timeout <= 1'b1;
        end else if (w_start_ok) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= r_timeout;
        end
    end

    assign timeout_o = r_timeout;
`else
    assign w_timeout_exp = 1'b0;
    assign timeout_o     = 1'b0;
`endif

    assign theta_iteration_valid_o = r_req_valid;
    assign theta_iteration_o       = w_index;
    assign res_valid_o             = r_res_valid;
    assign res_data_o              = r_res_data;
    assign res_column_o            = r_res_col;
    assign res_frame_o             = r_res_frm;
    assign busy_o                  = r_busy;
    assign done_o                  = r_done;

endmodule
